// File: rtl/mc_ctrl_if.sv
// Control/datapath bundle for mc_ctrl: decode inputs, MIO handshake and control strobes.
// The bne strobe exists only when MCTRL_BNE_EN is defined.
interface mc_ctrl_if;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       zero;
  logic       MIO_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALU_Control;
  logic       CPU_MIO;
  logic [3:0] state_out;
`ifdef MCTRL_BNE_EN
  logic       bne;
`endif

  modport master (
    input  OPcode, Fun, zero, MIO_ready,
    output
`ifdef MCTRL_BNE_EN
           bne,
`endif
           PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALU_Control, CPU_MIO,
           state_out
  );

  modport slave (
    output OPcode, Fun, zero, MIO_ready,
    input
`ifdef MCTRL_BNE_EN
           bne,
`endif
           PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALU_Control, CPU_MIO,
           state_out
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM; MCTRL_BNE_EN adds bne through the BEQ state.
// Latency: strobes are Moore outputs of the state register; IF IRWrite/PCWrite also gated by MIO_ready.
// Backpressure: IF, MR and MW hold until MIO_ready; strobes stay stable while stalled.
module mc_ctrl (
  input logic       clk,
  input logic       rst,
  mc_ctrl_if.master bus
);

  localparam logic [3:0] S_IF  = 4'd0;
  localparam logic [3:0] S_ID  = 4'd1;
  localparam logic [3:0] S_MA  = 4'd2;
  localparam logic [3:0] S_MR  = 4'd3;
  localparam logic [3:0] S_WBM = 4'd4;
  localparam logic [3:0] S_MW  = 4'd5;
  localparam logic [3:0] S_EXR = 4'd6;
  localparam logic [3:0] S_WBR = 4'd7;
  localparam logic [3:0] S_BEQ = 4'd8;
  localparam logic [3:0] S_J   = 4'd9;
  localparam logic [3:0] S_EXI = 4'd10;
  localparam logic [3:0] S_WBI = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef MCTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [2:0] fun_alu;
  logic       fun_ok;

  always_comb begin
    fun_alu = 3'b000;
    fun_ok  = 1'b1;
    case (bus.Fun)
      6'b100000: fun_alu = 3'b010;
      6'b100010: fun_alu = 3'b110;
      6'b100100: fun_alu = 3'b000;
      6'b100101: fun_alu = 3'b001;
      6'b100110: fun_alu = 3'b011;
      6'b100111: fun_alu = 3'b100;
      6'b101010: fun_alu = 3'b111;
      6'b000010: fun_alu = 3'b101;
      default:   fun_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IF;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF: state_nxt = bus.MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (bus.OPcode)
          OP_RTYPE:         state_nxt = S_EXR;
          OP_LW, OP_SW:     state_nxt = S_MA;
          OP_BEQ:           state_nxt = S_BEQ;
`ifdef MCTRL_BNE_EN
          OP_BNE:           state_nxt = S_BEQ;
`endif
          OP_J:             state_nxt = S_J;
          OP_ADDI, OP_SLTI: state_nxt = S_EXI;
          default:          state_nxt = S_IF;
        endcase
      end
      S_MA:  state_nxt = (bus.OPcode == OP_LW) ? S_MR : S_MW;
      S_MR:  state_nxt = bus.MIO_ready ? S_WBM : S_MR;
      S_MW:  state_nxt = bus.MIO_ready ? S_IF : S_MW;
      S_EXR: state_nxt = fun_ok ? S_WBR : S_IF;
      S_EXI: state_nxt = S_WBI;
      default: state_nxt = S_IF;
    endcase
  end

  // Outputs forced low for the whole reset window, not just after the state clears.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.ALU_Control = 3'b000;
    bus.CPU_MIO     = 1'b0;
`ifdef MCTRL_BNE_EN
    bus.bne         = 1'b0;
`endif
    if (rst) begin
      case (state)
        S_IF: begin
          bus.MemRead     = 1'b1;
          bus.CPU_MIO     = 1'b1;
          bus.ALUSrcB     = 2'b01;
          bus.ALU_Control = 3'b010;
          bus.IRWrite     = bus.MIO_ready;
          bus.PCWrite     = bus.MIO_ready;
        end
        S_ID: begin
          bus.ALUSrcB     = 2'b11;
          bus.ALU_Control = 3'b010;
        end
        S_MA: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUSrcB     = 2'b10;
          bus.ALU_Control = 3'b010;
        end
        S_MR: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
          bus.CPU_MIO = 1'b1;
        end
        S_WBM: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        S_MW: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
          bus.CPU_MIO  = 1'b1;
        end
        S_EXR: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALU_Control = fun_alu;
        end
        S_WBR: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        S_BEQ: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALU_Control = 3'b110;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
`ifdef MCTRL_BNE_EN
          bus.bne         = (bus.OPcode == OP_BNE);
`endif
        end
        S_J: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
        end
        S_EXI: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUSrcB     = 2'b10;
          bus.ALU_Control = (bus.OPcode == OP_SLTI) ? 3'b111 : 3'b010;
        end
        S_WBI: bus.RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  // Async reset parks the state at IF (code 0), so no extra gating is needed here.
  assign bus.state_out = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: cycle-count vector table, directed stall/reset sequences, random instructions vs phase model.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rst;

  mc_ctrl_if bus ();
  mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [3:0] P_IF = 4'd0, P_ID = 4'd1, P_MA = 4'd2, P_MR = 4'd3, P_WBM = 4'd4,
                         P_MW = 4'd5, P_EXR = 4'd6, P_WBR = 4'd7, P_BEQ = 4'd8, P_J = 4'd9,
                         P_EXI = 4'd10, P_WBI = 4'd11;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb, pcsrc;
    logic [2:0] alu;
    logic       mio;
    logic [3:0] st;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fun;
    int         cycles;
    int         rwr;
    int         mwr;
    int         pcwc;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] phq[$];
  vec_t       vt[13];
  logic [5:0] known_fun[8];

  function automatic bit fun_known(input logic [5:0] f);
    foreach (known_fun[i]) if (known_fun[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] fun_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100110: return 3'b011;
      6'b100111: return 3'b100;
      6'b101010: return 3'b111;
      default:   return 3'b101;
    endcase
  endfunction

  // Instruction class -> list of phases visited.
  function automatic void build(input logic [5:0] op, input logic [5:0] fun);
    phq.delete();
    phq.push_back(P_IF);
    phq.push_back(P_ID);
    case (op)
      6'b000000: begin phq.push_back(P_EXR); if (fun_known(fun)) phq.push_back(P_WBR); end
      6'b100011: begin phq.push_back(P_MA); phq.push_back(P_MR); phq.push_back(P_WBM); end
      6'b101011: begin phq.push_back(P_MA); phq.push_back(P_MW); end
      6'b000100: phq.push_back(P_BEQ);
`ifdef MCTRL_BNE_EN
      6'b000101: phq.push_back(P_BEQ);
`endif
      6'b000010: phq.push_back(P_J);
      6'b001000, 6'b001010: begin phq.push_back(P_EXI); phq.push_back(P_WBI); end
      default: ;
    endcase
  endfunction

  function automatic ctrl_t exp_ctrl(input logic [3:0] p, input logic [5:0] op,
                                     input logic [5:0] fun, input logic rdy);
    ctrl_t e;
    e = '0;
    e.st = p;
    case (p)
      P_IF:  begin e.mrd = 1; e.mio = 1; e.srcb = 2'b01; e.alu = 3'b010; e.irw = rdy; e.pcw = rdy; end
      P_ID:  begin e.srcb = 2'b11; e.alu = 3'b010; end
      P_MA:  begin e.srca = 1; e.srcb = 2'b10; e.alu = 3'b010; end
      P_MR:  begin e.mrd = 1; e.iord = 1; e.mio = 1; end
      P_WBM: begin e.rwr = 1; e.m2r = 1; end
      P_MW:  begin e.mwr = 1; e.iord = 1; e.mio = 1; end
      P_EXR: begin e.srca = 1; e.alu = fun_alu(fun); end
      P_WBR: begin e.rwr = 1; e.rdst = 1; end
      P_BEQ: begin e.srca = 1; e.alu = 3'b110; e.pcwc = 1; e.pcsrc = 2'b01; end
      P_J:   begin e.pcw = 1; e.pcsrc = 2'b10; end
      P_EXI: begin e.srca = 1; e.srcb = 2'b10; e.alu = (op == 6'b001010) ? 3'b111 : 3'b010; end
      P_WBI: e.rwr = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctrl_t sample();
    ctrl_t c;
    c.pcw = bus.PCWrite;   c.pcwc = bus.PCWriteCond; c.iord = bus.IorD;
    c.mrd = bus.MemRead;   c.mwr = bus.MemWrite;     c.irw = bus.IRWrite;
    c.m2r = bus.MemtoReg;  c.rdst = bus.RegDst;      c.rwr = bus.RegWrite;
    c.srca = bus.ALUSrcA;  c.srcb = bus.ALUSrcB;     c.pcsrc = bus.PCSource;
    c.alu = bus.ALU_Control; c.mio = bus.CPU_MIO;    c.st = bus.state_out;
    return c;
  endfunction

  task automatic check(input string name, input logic [3:0] p, input logic [5:0] op,
                       input logic [5:0] fun, input logic rdy);
    ctrl_t g, e;
    g = sample();
    e = exp_ctrl(p, op, fun, rdy);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s phase=%0d op=%b fun=%b: got %h, expected %h", name, p, op, fun, g, e);
    end
    if (p == P_BEQ && bus.zero) begin
      n_cmp++;
      if ((bus.PCWriteCond & bus.zero) !== 1'b1) begin
        n_bad++;
        $display("FAIL %s branch_taken: got 0, expected 1", name);
      end
    end
`ifdef MCTRL_BNE_EN
    n_cmp++;
    if (bus.bne !== (p == P_BEQ && op == 6'b000101)) begin
      n_bad++;
      $display("FAIL %s bne phase=%0d: got %b", name, p, bus.bne);
    end
`endif
  endtask

  task automatic check_zero(input string name);
    ctrl_t g;
    g = sample();
    n_cmp++;
    if (g !== '0) begin
      n_bad++;
      $display("FAIL %s: got %h, expected 0", name, g);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Runs one instruction from IF, stalling sif cycles in IF and smem cycles in MR/MW.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fun,
                           input int sif, input int smem, input logic z);
    logic [3:0] p;
    int         n;
    bus.OPcode = op;
    bus.Fun    = fun;
    bus.zero   = z;
    build(op, fun);
    foreach (phq[i]) begin
      p = phq[i];
      if (p == P_IF || p == P_MR || p == P_MW) begin
        n = (p == P_IF) ? sif : smem;
        for (int k = 0; k < n; k++) begin
          bus.MIO_ready = 1'b0;
          @(negedge clk); check("stall", p, op, fun, 1'b0);
          @(posedge clk); #1;
        end
        bus.MIO_ready = 1'b1;
        @(negedge clk); check("ready", p, op, fun, 1'b1);
        @(posedge clk); #1;
      end else begin
        bus.MIO_ready = 1'($urandom_range(0, 1));
        @(negedge clk); check("phase", p, op, fun, bus.MIO_ready);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_vec(input int idx);
    int cyc, rw, mw, pc;
    cyc = 0; rw = 0; mw = 0; pc = 0;
    bus.OPcode = vt[idx].op;
    bus.Fun = vt[idx].fun;
    bus.zero = 1'b0;
    bus.MIO_ready = 1'b1;
    do begin
      @(negedge clk);
      rw += int'(bus.RegWrite);
      mw += int'(bus.MemWrite);
      pc += int'(bus.PCWriteCond);
      cyc++;
      @(posedge clk); #1;
    end while (bus.state_out != 4'd0 && cyc < 20);
    cmp_int($sformatf("vec%0d_cycles", idx), cyc, vt[idx].cycles);
    cmp_int($sformatf("vec%0d_regwrite", idx), rw, vt[idx].rwr);
    cmp_int($sformatf("vec%0d_memwrite", idx), mw, vt[idx].mwr);
    cmp_int($sformatf("vec%0d_pcwritecond", idx), pc, vt[idx].pcwc);
  endtask

  initial begin
    logic [5:0] op, fun;
    known_fun = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                  6'b100110, 6'b100111, 6'b101010, 6'b000010};
    vt[0]  = '{6'b100011, 6'b000000, 5, 1, 0, 0};
    vt[1]  = '{6'b101011, 6'b000000, 4, 0, 1, 0};
    vt[2]  = '{6'b000000, 6'b100000, 4, 1, 0, 0};
    vt[3]  = '{6'b000000, 6'b100010, 4, 1, 0, 0};
    vt[4]  = '{6'b000000, 6'b000010, 4, 1, 0, 0};
    vt[5]  = '{6'b000000, 6'b101010, 4, 1, 0, 0};
    vt[6]  = '{6'b000000, 6'b111111, 3, 0, 0, 0};
    vt[7]  = '{6'b001000, 6'b000000, 4, 1, 0, 0};
    vt[8]  = '{6'b001010, 6'b000000, 4, 1, 0, 0};
    vt[9]  = '{6'b000100, 6'b000000, 3, 0, 0, 1};
    vt[10] = '{6'b000010, 6'b000000, 3, 0, 0, 0};
    vt[11] = '{6'b111111, 6'b000000, 2, 0, 0, 0};
`ifdef MCTRL_BNE_EN
    vt[12] = '{6'b000101, 6'b000000, 3, 0, 0, 1};
`else
    vt[12] = '{6'b000101, 6'b000000, 2, 0, 0, 0};
`endif

    rst = 1'b0;
    bus.OPcode = 6'b100011;
    bus.Fun = 6'b000000;
    bus.zero = 1'b0;
    bus.MIO_ready = 1'b0;
    #3 check_zero("reset_hold");
    repeat (2) @(posedge clk);
    @(negedge clk); check_zero("reset_hold_edge");
    rst = 1'b1;
    #1 check("post_reset_if", P_IF, 6'b100011, 6'b000000, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(i);

    run_instr(6'b000000, 6'b100000, 2, 0, 1'b0);
    run_instr(6'b100011, 6'b000000, 0, 3, 1'b0);
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b1);
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b000101, 6'b000000, 0, 0, 1'b1);
    run_instr(6'b101011, 6'b000000, 1, 2, 1'b0);

    // Abort a load while it is waiting in MR.
    bus.OPcode = 6'b100011;
    bus.MIO_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.MIO_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); check("mr_before_reset", P_MR, 6'b100011, 6'b000000, 1'b0);
    #1 rst = 1'b0;
    #1 check_zero("reset_mid_mr");
    @(posedge clk);
    @(negedge clk); check_zero("reset_mid_mr_edge");
    rst = 1'b1;
    #1 check("if_after_mr_reset", P_IF, 6'b100011, 6'b000000, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      fun = known_fun[$urandom_range(0, 7)];
      case ($urandom_range(0, 9))
        0, 9:    op = 6'b000000;
        1:       op = 6'b100011;
        2:       op = 6'b101011;
        3:       op = 6'b000100;
        4:       op = 6'b000010;
        5:       op = 6'b001000;
        6:       op = 6'b001010;
        7:       op = 6'b000101;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fun, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
